// File: rtl/l2_cache_assoc.sv
// N-way set-associative, write-back, write-allocate L2 cache with true-LRU replacement
// and performance counters. Line-granular request/response on both sides.
module l2_cache_assoc #(
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int SET_BITS = 5,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [CNT_W-1:0]  access_cnt
);

  localparam int SETS     = 1 << SET_BITS;
  localparam int TAG_W    = ADDR_W - SET_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];
  logic [WAY_BITS-1:0] age_q   [SETS][WAYS];

  logic [WAY_BITS-1:0] vic_q;
  logic                miss_flag_q;

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag_in;
  logic                req;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                vic_found;
  logic [WAY_BITS-1:0] vic_sel;
  logic                vic_dirty;
  logic                touch_en;
  logic [WAY_BITS-1:0] touch_way;

  assign idx    = l2_addr[SET_BITS-1:0];
  assign tag_in = l2_addr[ADDR_W-1:SET_BITS];
  assign req    = l2_read | l2_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim: lowest-index invalid way first, otherwise the oldest way.
  always_comb begin
    vic_found = 1'b0;
    vic_sel   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[idx][w]) begin
        vic_found = 1'b1;
        vic_sel   = WAY_BITS'(w);
      end
    end
    if (!vic_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == WAY_BITS'(WAYS - 1)) vic_sel = WAY_BITS'(w);
      end
    end
  end

  assign vic_dirty = valid_q[idx][vic_sel] & dirty_q[idx][vic_sel];

  assign l2_ready = reset | ((state_q == S_IDLE) & (~req | hit));
  assign l2_rdata = (!reset && (state_q == S_IDLE) && hit && l2_read && !l2_write)
                    ? data_q[idx][hit_way] : '0;

  always_comb begin
    touch_en  = 1'b0;
    touch_way = hit_way;
    if ((state_q == S_IDLE) && req && hit) begin
      touch_en = 1'b1;
    end else if ((state_q == S_FILL) && mem_ready) begin
      touch_en  = 1'b1;
      touch_way = vic_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req && !hit) state_d = vic_dirty ? S_WB : S_FILL;
      S_WB:   if (mem_ready) state_d = S_FILL;
      S_FILL: if (mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
      vic_q       <= '0;
      miss_flag_q <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      wb_cnt      <= '0;
      access_cnt  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            if (l2_write) begin
              data_q[idx][hit_way]  <= l2_wdata;
              dirty_q[idx][hit_way] <= 1'b1;
            end
            access_cnt  <= access_cnt + 1'b1;
            if (!miss_flag_q) hit_cnt <= hit_cnt + 1'b1;
            miss_flag_q <= 1'b0;
          end else if (req) begin
            vic_q       <= vic_sel;
            miss_flag_q <= 1'b1;
            miss_cnt    <= miss_cnt + 1'b1;
            if (vic_dirty) begin
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[idx][vic_sel], idx};
              mem_wdata <= data_q[idx][vic_sel];
              wb_cnt    <= wb_cnt + 1'b1;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= l2_addr;
            end
          end
        end
        S_WB: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= l2_addr;
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            tag_q[idx][vic_q]   <= tag_in;
            data_q[idx][vic_q]  <= mem_rdata;
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= 1'b0;
            mem_read            <= 1'b0;
          end
        end
        default: ;
      endcase

      // Ages younger than the touched way shift up one, so the set stays a permutation.
      if (touch_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == touch_way)
            age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][touch_way])
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Self-checking bench for l2_cache_assoc: directed scenarios plus randomized traffic
// against a recency-stamp cache model and a sparse main-memory model.
module tb_l2_cache_assoc;
  localparam int ADDR_W = 28, LINE_W = 128, SET_BITS = 5, WAYS = 2, CNT_W = 32;
  localparam int SETS = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata, l2_rdata;
  logic              l2_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt, wb_cnt, access_cnt;

  l2_cache_assoc #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SET_BITS(SET_BITS),
                   .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .l2_read(l2_read), .l2_write(l2_write),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt), .access_cnt(access_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  logic [22:0] m_tag   [WAYS][SETS];
  logic [127:0] m_data [WAYS][SETS];
  int          m_stamp [WAYS][SETS];
  int          tick = 0;
  int          e_hit, e_miss, e_wb, e_acc;
  logic [127:0] mem_store [logic [27:0]];

  function automatic logic [127:0] mem_get(input logic [27:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    if (mem_store.exists(a)) return mem_store[a];
    return {x * 32'h9E37_79B1, ~x, x ^ 32'h5A5A_0F0F, x + 32'h1234_5678};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 0; m_dirty[w][s] = 0; m_tag[w][s] = '0;
        m_data[w][s] = '0; m_stamp[w][s] = 0;
      end
    e_hit = 0; e_miss = 0; e_wb = 0; e_acc = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1; l2_read = 0; l2_write = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // One full request: first-cycle lookup, optional writeback and fill, completion, counters.
  task automatic do_req(input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] wd, input int lat, input string nm);
    int s, hw, vw;
    logic [22:0] tg;
    bit missed;
    logic [27:0] waddr;
    logic [127:0] exp_rd;
    s = int'(addr[4:0]); tg = addr[27:5]; hw = -1; missed = 0;
    for (int w = 0; w < WAYS; w++) if (m_valid[w][s] && m_tag[w][s] == tg) hw = w;
    @(negedge clk);
    l2_read = rd; l2_write = wr; l2_addr = addr; l2_wdata = wd; mem_ready = 0;
    #1;
    if (hw < 0) begin
      missed = 1;
      vw = -1;
      for (int w = 0; w < WAYS; w++) if (vw < 0 && !m_valid[w][s]) vw = w;
      if (vw < 0) begin
        vw = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[w][s] < m_stamp[vw][s]) vw = w;
      end
      checks++;
      if (l2_ready !== 1'b0) begin
        failures++; $display("FAIL %s miss_ready: got %b expected 0", nm, l2_ready);
      end
      e_miss++;
      if (m_valid[vw][s] && m_dirty[vw][s]) begin
        e_wb++;
        waddr = {m_tag[vw][s], addr[4:0]};
        for (int c = 0; c < lat; c++) begin
          @(negedge clk); mem_ready = 0; #1;
          checks++;
          if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== waddr ||
              mem_wdata !== m_data[vw][s] || l2_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s wb_phase: got w=%b r=%b addr=%h data=%h rdy=%b expected w=1 r=0 addr=%h data=%h rdy=0",
                     nm, mem_write, mem_read, mem_addr, mem_wdata, l2_ready, waddr, m_data[vw][s]);
          end
          if (c == lat - 1) mem_ready = 1;
        end
        mem_store[waddr] = m_data[vw][s];
      end
      for (int c = 0; c < lat; c++) begin
        @(negedge clk); mem_ready = 0; mem_rdata = {4{$urandom}}; #1;
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== addr || l2_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s fill_phase: got r=%b w=%b addr=%h rdy=%b expected r=1 w=0 addr=%h rdy=0",
                   nm, mem_read, mem_write, mem_addr, l2_ready, addr);
        end
        if (c == lat - 1) begin mem_rdata = mem_get(addr); mem_ready = 1; end
      end
      @(negedge clk); mem_ready = 0; mem_rdata = {4{$urandom}}; #1;
      m_valid[vw][s] = 1; m_tag[vw][s] = tg; m_data[vw][s] = mem_get(addr); m_dirty[vw][s] = 0;
      tick++; m_stamp[vw][s] = tick;
      hw = vw;
    end
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      failures++; $display("FAIL %s mem_idle: got r=%b w=%b expected r=0 w=0", nm, mem_read, mem_write);
    end
    exp_rd = (rd && !wr) ? m_data[hw][s] : '0;
    checks++;
    if (l2_ready !== 1'b1 || l2_rdata !== exp_rd) begin
      failures++;
      $display("FAIL %s complete: got rdy=%b rdata=%h expected rdy=1 rdata=%h", nm, l2_ready, l2_rdata, exp_rd);
    end
    if (wr) begin m_data[hw][s] = wd; m_dirty[hw][s] = 1; end
    tick++; m_stamp[hw][s] = tick;
    e_acc++;
    if (!missed) e_hit++;
    @(negedge clk); l2_read = 0; l2_write = 0; #1;
    checks++;
    if (hit_cnt !== CNT_W'(e_hit) || miss_cnt !== CNT_W'(e_miss) ||
        wb_cnt !== CNT_W'(e_wb) || access_cnt !== CNT_W'(e_acc)) begin
      failures++;
      $display("FAIL %s counters: got h=%0d m=%0d wb=%0d a=%0d expected h=%0d m=%0d wb=%0d a=%0d",
               nm, hit_cnt, miss_cnt, wb_cnt, access_cnt, e_hit, e_miss, e_wb, e_acc);
    end
  endtask

  task automatic test_reset();
    reset = 1; l2_read = 1; l2_write = 0; l2_addr = 28'h20; l2_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    model_reset();
    #12;
    checks++;
    if (l2_ready !== 1'b1 || l2_rdata !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b rdata=%h r=%b w=%b addr=%h expected rdy=1 rdata=0 r=0 w=0 addr=0",
               l2_ready, l2_rdata, mem_read, mem_write, mem_addr);
    end
    checks++;
    if (hit_cnt !== '0 || miss_cnt !== '0 || wb_cnt !== '0 || access_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counters: got %0d %0d %0d %0d expected all 0", hit_cnt, miss_cnt, wb_cnt, access_cnt);
    end
    l2_read = 0;
    @(negedge clk); reset = 0;
  endtask

  task automatic test_cold_read();
    do_req(1, 0, 28'h0000020, '0, 3, "cold_read");
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0 || access_cnt !== 32'd1) begin
      failures++;
      $display("FAIL cold_counts: got m=%0d h=%0d a=%0d expected m=1 h=0 a=1", miss_cnt, hit_cnt, access_cnt);
    end
  endtask

  task automatic test_write_read();
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_req(0, 1, 28'h0000020, wd, 2, "hit_write");
    do_req(1, 0, 28'h0000020, '0, 2, "hit_read");
    checks++;
    if (hit_cnt !== 32'd2) begin
      failures++; $display("FAIL write_read_hits: got %0d expected 2", hit_cnt);
    end
  endtask

  task automatic test_lru_evict();
    apply_reset();
    do_req(1, 0, 28'h20, '0, 1, "lru_A");
    do_req(1, 0, 28'h40, '0, 2, "lru_B");
    do_req(1, 0, 28'h60, '0, 1, "lru_C");
    do_req(1, 0, 28'h40, '0, 1, "lru_B_again");
    checks++;
    if (miss_cnt !== 32'd3 || hit_cnt !== 32'd1) begin
      failures++; $display("FAIL lru_B_hit: got m=%0d h=%0d expected m=3 h=1", miss_cnt, hit_cnt);
    end
    do_req(1, 0, 28'h20, '0, 1, "lru_A_again");
    checks++;
    if (miss_cnt !== 32'd4) begin
      failures++; $display("FAIL lru_A_evicted: got m=%0d expected 4", miss_cnt);
    end
  endtask

  task automatic test_writeback();
    apply_reset();
    do_req(0, 1, 28'h20, {4{32'hAAAA_0001}}, 1, "wb_write_A");
    do_req(0, 1, 28'h40, {4{32'hBBBB_0002}}, 2, "wb_write_B");
    do_req(1, 0, 28'h60, '0, 3, "wb_read_C");
    checks++;
    if (wb_cnt !== 32'd1 || !mem_store.exists(28'h20) || mem_store[28'h20] !== {4{32'hAAAA_0001}}) begin
      failures++; $display("FAIL wb_of_A: got wb=%0d expected wb=1 with line A written", wb_cnt);
    end
    do_req(1, 0, 28'h40, '0, 1, "wb_B_resident");
    do_req(1, 0, 28'h20, '0, 2, "wb_A_refetch");
  endtask

  task automatic test_reset_during_wb();
    apply_reset();
    do_req(0, 1, 28'h20, {4{32'h1111_2222}}, 1, "rst_write_A");
    do_req(0, 1, 28'h40, {4{32'h3333_4444}}, 1, "rst_write_B");
    @(negedge clk); l2_read = 1; l2_addr = 28'h60; mem_ready = 0;
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b1) begin
      failures++; $display("FAIL rst_wb_started: got mem_write=%b expected 1", mem_write);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0 || l2_ready !== 1'b1 ||
        l2_rdata !== '0 || wb_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid_wb: got w=%b r=%b addr=%h rdy=%b rdata=%h wb=%0d expected w=0 r=0 addr=0 rdy=1 rdata=0 wb=0",
               mem_write, mem_read, mem_addr, l2_ready, l2_rdata, wb_cnt);
    end
    l2_read = 0;
    model_reset();
    @(negedge clk); reset = 0;
    do_req(1, 0, 28'h20, '0, 2, "rst_A_misses");
    checks++;
    if (miss_cnt !== 32'd1) begin
      failures++; $display("FAIL rst_A_miss_cnt: got %0d expected 1", miss_cnt);
    end
  endtask

  task automatic test_idle_mem_ready();
    do_req(1, 0, 28'h45, '0, 1, "idle_prime");
    @(negedge clk); mem_ready = 1; mem_rdata = {4{$urandom}};
    repeat (3) @(negedge clk);
    mem_ready = 0; #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || l2_ready !== 1'b1 ||
        hit_cnt !== CNT_W'(e_hit) || miss_cnt !== CNT_W'(e_miss) ||
        wb_cnt !== CNT_W'(e_wb) || access_cnt !== CNT_W'(e_acc)) begin
      failures++;
      $display("FAIL idle_mem_ready: got r=%b w=%b rdy=%b h=%0d m=%0d a=%0d expected r=0 w=0 rdy=1 h=%0d m=%0d a=%0d",
               mem_read, mem_write, l2_ready, hit_cnt, miss_cnt, access_cnt, e_hit, e_miss, e_acc);
    end
    do_req(1, 0, 28'h45, '0, 1, "idle_still_hit");
  endtask

  task automatic test_random();
    logic [27:0] a;
    int op;
    for (int i = 0; i < 200; i++) begin
      a = {23'($urandom_range(0, 4)), 5'($urandom_range(0, 1))};
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, a, {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(1, 4), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_read();
    test_lru_evict();
    test_writeback();
    test_reset_during_wb();
    test_idle_mem_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
